// File: rtl/amns_seq_pkg.sv
// Shared definitions for the AMNS vector sequencer.
//   seq_state_t   : sequencer FSM states
//   *_BASE        : operand word bases for the default N=5, s=4 build
//   load_words()  : number of operand words streamed into BRAM per run
//   word_to_byte(): BRAM word index to byte address
package amns_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT,
        READ,
        CMP,
        FINISH
    } seq_state_t;

    localparam int unsigned DEF_N      = 5;
    localparam int unsigned DEF_S      = 4;
    localparam int unsigned MP0_BASE   = 0;
    localparam int unsigned M_BASE     = DEF_N;
    localparam int unsigned A_BASE     = (DEF_S + 1) * DEF_N;
    localparam int unsigned B_BASE     = (2 * DEF_S + 1) * DEF_N;
    localparam int unsigned LOAD_WORDS = (3 * DEF_S + 1) * DEF_N;

    // M_prime_0 (n words) followed by M, A and B (n*s words each).
    function automatic int load_words(input int n, input int s_l);
        return (3 * s_l + 1) * n;
    endfunction

    function automatic logic [31:0] word_to_byte(input logic [31:0] word_idx);
        return {word_idx[29:0], 2'b00};
    endfunction

endpackage

// File: rtl/amns_seq_stats.sv
// Run statistics for the AMNS vector sequencer.
// Inputs : clock_i, reset_i (async, active low), run_clr (new run accepted),
//          cyc_clr / cyc_inc (core latency counter control), timeout_set,
//          finish (end-of-run strobe), clean (no limb mismatches this run).
// Outputs: cycle_cnt, cyc_last (next increment reaches TIMEOUT), timeout,
//          pass, vec_cnt, pass_cnt.
module amns_seq_stats #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 100000
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             run_clr,
    input  logic             cyc_clr,
    input  logic             cyc_inc,
    input  logic             timeout_set,
    input  logic             finish,
    input  logic             clean,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic             cyc_last,
    output logic             timeout,
    output logic             pass,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] pass_cnt
);

    logic run_ok;

    // The timeout flag is already registered by the time finish is seen.
    assign run_ok   = clean && !timeout;
    assign cyc_last = (cycle_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            cycle_cnt <= '0;
            timeout   <= 1'b0;
            pass      <= 1'b0;
            vec_cnt   <= '0;
            pass_cnt  <= '0;
        end else begin
            if (run_clr) begin
                cycle_cnt <= '0;
                timeout   <= 1'b0;
                pass      <= 1'b0;
            end
            if (cyc_clr) begin
                cycle_cnt <= '0;
            end
            if (cyc_inc) begin
                cycle_cnt <= cycle_cnt + 1'b1;
            end
            if (timeout_set) begin
                timeout <= 1'b1;
            end
            if (finish) begin
                vec_cnt <= vec_cnt + 1'b1;
                pass    <= run_ok;
                if (run_ok) begin
                    pass_cnt <= pass_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/amns_vector_sequencer.sv
// Drives one AMNS/FIOS Montgomery multiplier run from a limb stream:
// loads M_prime_0, M, A, B into BRAM, pulses the core start, times the core,
// then reads back the N*s result limbs and checks them against expected limbs
// taken from the same stream.
// Ports: clock_i/reset_i; run_i; limb stream vec_valid_i/vec_data_i/vec_ready_o;
//        BRAM port A bram_addr_o/bram_din_o/bram_we_o/bram_en_o/bram_dout_i;
//        core_start_o/core_done_i; status busy_o, done_o, pass_o, timeout_o,
//        mismatch_cnt_o, cycle_cnt_o, vec_cnt_o, pass_cnt_o.
//
// state  | meaning
// IDLE   | waiting for run_i
// LOAD   | writing streamed operand limbs into BRAM
// START  | one-cycle core start pulse
// WAIT   | counting core latency until done or timeout
// READ   | issuing one result-limb BRAM read
// CMP    | comparing read limb with the next expected stream limb
// FINISH | end-of-run pulse, statistics update
module amns_vector_sequencer
    import amns_seq_pkg::*;
#(
    parameter int LIMB_W   = 17,
    parameter int N        = 5,
    parameter int s        = 4,
    parameter int ADDR_W   = 32,
    parameter int RES_BASE = 0,
    parameter int CNT_W    = 32,
    parameter int TIMEOUT  = 100000
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              run_i,
    input  logic              vec_valid_i,
    input  logic [LIMB_W-1:0] vec_data_i,
    output logic              vec_ready_o,
    output logic [ADDR_W-1:0] bram_addr_o,
    output logic [31:0]       bram_din_o,
    output logic [3:0]        bram_we_o,
    output logic              bram_en_o,
    input  logic [31:0]       bram_dout_i,
    output logic              core_start_o,
    input  logic              core_done_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic              timeout_o,
    output logic [7:0]        mismatch_cnt_o,
    output logic [CNT_W-1:0]  cycle_cnt_o,
    output logic [CNT_W-1:0]  vec_cnt_o,
    output logic [CNT_W-1:0]  pass_cnt_o
);

    localparam int LOAD_W = load_words(N, s);
    localparam int RES_W  = N * s;
    localparam int K_W    = $clog2(LOAD_W + 1);
    localparam int R_W    = $clog2(RES_W + 1);

    seq_state_t     state_q, state_d;
    logic [K_W-1:0] k_q;
    logic [R_W-1:0] r_q;
    logic [7:0]     mis_q;

    logic run_acc, load_acc, cmp_acc, limb_bad;
    logic k_last, r_last;
    logic cyc_inc, cyc_last, timeout_set;

    assign run_acc  = (state_q == IDLE) && run_i;
    assign load_acc = (state_q == LOAD) && vec_valid_i;
    assign cmp_acc  = (state_q == CMP) && vec_valid_i;
    assign limb_bad = cmp_acc && (bram_dout_i[LIMB_W-1:0] != vec_data_i);
    assign k_last   = (k_q == K_W'(LOAD_W - 1));
    assign r_last   = (r_q == R_W'(RES_W - 1));

    generate
        if (LIMB_W < 32) begin : g_unused_dout
            logic unused_dout_hi;
            assign unused_dout_hi = ^bram_dout_i[31:LIMB_W];
        end
    endgenerate

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= IDLE;
            k_q     <= '0;
            r_q     <= '0;
            mis_q   <= '0;
        end else begin
            state_q <= state_d;
            if (run_acc) begin
                k_q   <= '0;
                mis_q <= '0;
            end
            if (load_acc) begin
                k_q <= k_q + 1'b1;
            end
            if ((state_q == WAIT) && core_done_i) begin
                r_q <= '0;
            end
            if (cmp_acc) begin
                r_q <= r_q + 1'b1;
            end
            if (limb_bad && (mis_q != 8'hFF)) begin
                mis_q <= mis_q + 8'd1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cyc_inc      = 1'b0;
        timeout_set  = 1'b0;
        vec_ready_o  = 1'b0;
        bram_en_o    = 1'b0;
        bram_we_o    = 4'h0;
        bram_addr_o  = '0;
        bram_din_o   = '0;
        core_start_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (run_i) state_d = LOAD;
            end
            LOAD: begin
                vec_ready_o = 1'b1;
                if (load_acc) begin
                    bram_en_o   = 1'b1;
                    bram_we_o   = 4'hF;
                    bram_addr_o = ADDR_W'(word_to_byte(32'(k_q)));
                    bram_din_o  = 32'(vec_data_i);
                    if (k_last) state_d = START;
                end
            end
            START: begin
                core_start_o = 1'b1;
                state_d      = WAIT;
            end
            WAIT: begin
                // Done takes priority: a done seen on the last allowed cycle is a valid finish.
                if (core_done_i) begin
                    state_d = READ;
                end else begin
                    cyc_inc = 1'b1;
                    if (cyc_last) begin
                        timeout_set = 1'b1;
                        state_d     = FINISH;
                    end
                end
            end
            READ: begin
                bram_en_o   = 1'b1;
                bram_addr_o = ADDR_W'(word_to_byte(32'(RES_BASE) + 32'(r_q)));
                state_d     = CMP;
            end
            CMP: begin
                // BRAM is disabled here, so its output register keeps the read limb.
                vec_ready_o = 1'b1;
                if (cmp_acc) state_d = r_last ? FINISH : READ;
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy_o         = (state_q != IDLE);
    assign done_o         = (state_q == FINISH);
    assign mismatch_cnt_o = mis_q;

    amns_seq_stats #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_stats (
        .clock_i     (clock_i),
        .reset_i     (reset_i),
        .run_clr     (run_acc),
        .cyc_clr     (state_q == START),
        .cyc_inc     (cyc_inc),
        .timeout_set (timeout_set),
        .finish      (state_q == FINISH),
        .clean       (mis_q == 8'd0),
        .cycle_cnt   (cycle_cnt_o),
        .cyc_last    (cyc_last),
        .timeout     (timeout_o),
        .pass        (pass_o),
        .vec_cnt     (vec_cnt_o),
        .pass_cnt    (pass_cnt_o)
    );

endmodule
